// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, AluOp codes, control word.
// MC_MULT_STALL_EN adds the MUL_WAIT state for the stalled multiply.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
`ifdef MC_MULT_STALL_EN
        , S_MUL_WAIT
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] OP_SPEC3 = 6'b011111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_FUNCT = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_ADDU  = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1010;
    localparam logic [3:0] ALU_SLTU  = 4'b1011;
    localparam logic [3:0] ALU_MUL   = 4'b1100;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       sign_ext;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic state_e decode_next(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_MUL, OP_SPEC3:                   return S_EXEC_R;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI:                     return S_EXEC_I;
            OP_LW, OP_SW:                                 return S_MEM_ADDR;
            OP_BEQ, OP_BNE:                               return S_BRANCH;
            OP_J:                                         return S_JUMP;
            default:                                      return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle: IR opcode and memory/ALU status in, control word out.
interface multicycle_control_fsm_if;
    logic [5:0] OpCode;
    logic       MemReady;
    logic       Zero;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       RegWrite;
    logic       MemToReg;
    logic       SignExt;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [3:0] AluOp;
    logic [1:0] PCSource;
    logic       Illegal;

    modport master (
        input  OpCode, MemReady, Zero,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
               RegWrite, MemToReg, SignExt, AluSrcA, AluSrcB, AluOp, PCSource, Illegal
    );
    modport slave (
        output OpCode, MemReady, Zero,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
               RegWrite, MemToReg, SignExt, AluSrcA, AluSrcB, AluOp, PCSource, Illegal
    );
endinterface

// File: rtl/multicycle_control_fsm_outdec.sv
// Pure combinational state + latched opcode -> control word decoder (Moore, except the
// FETCH IR/PC load which completes in the MemReady cycle).
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = 2'b01;
                ctrl_o.alu_op    = ALU_ADDU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = 2'b11;
                ctrl_o.alu_op    = ALU_ADDU;
            end
`ifdef MC_MULT_STALL_EN
            S_EXEC_R, S_MUL_WAIT: begin
`else
            S_EXEC_R: begin
`endif
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = (op_i == OP_MUL) ? ALU_MUL : ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b10;
                ctrl_o.sign_ext  = (op_i != OP_ADDIU);
                case (op_i)
                    OP_ADDI:  ctrl_o.alu_op = ALU_ADD;
                    OP_ADDIU: ctrl_o.alu_op = ALU_ADDU;
                    OP_ANDI:  ctrl_o.alu_op = ALU_AND;
                    OP_ORI:   ctrl_o.alu_op = ALU_OR;
                    OP_XORI:  ctrl_o.alu_op = ALU_XOR;
                    OP_SLTI:  ctrl_o.alu_op = ALU_SLT;
                    OP_SLTIU: ctrl_o.alu_op = ALU_SLTU;
                    default:  ctrl_o.alu_op = ALU_FUNCT;
                endcase
            end
            S_WB_R: ctrl_o.reg_write = 1'b1;
            S_WB_I: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b10;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.sign_ext  = 1'b1;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = 2'b01;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = 2'b10;
            end
            S_TRAP:  ctrl_o.illegal = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencer: state/opcode registers plus next-state logic; outputs via mc_ctrl_outdec.
// MC_MULT_STALL_EN adds a MULT_LATENCY-cycle MUL_WAIT stall for opcode 011100.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LATENCY = 4
) (
    input  logic                           Clk,
    input  logic                           Rst,
    multicycle_control_fsm_if.master       ctl_io
);

    if (MULT_LATENCY < 1 || MULT_LATENCY > 15) begin : g_bad_latency
        $error("MULT_LATENCY must be within 1..15");
    end

    state_e     state_q, state_d;
    logic [5:0] op_q;
    ctrl_t      ctrl;

    // IR is loaded at the end of FETCH, so the opcode is valid during DECODE and captured there.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= ctl_io.OpCode;
        end
    end

`ifdef MC_MULT_STALL_EN
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_EXEC_R)                      cnt_d = 4'(MULT_LATENCY - 1);
        else if (state_q == S_MUL_WAIT && cnt_q != '0) cnt_d = cnt_q - 4'd1;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (ctl_io.MemReady) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next(ctl_io.OpCode);
`ifdef MC_MULT_STALL_EN
            S_EXEC_R:   state_d = (op_q == OP_MUL) ? S_MUL_WAIT : S_WB_R;
            S_MUL_WAIT: if (cnt_q == '0) state_d = S_WB_R;
`else
            S_EXEC_R:   state_d = S_WB_R;
`endif
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (ctl_io.MemReady) state_d = S_WB_MEM;
            S_MEM_WR:   if (ctl_io.MemReady) state_d = S_FETCH;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .op_i        (op_q),
        .mem_ready_i (ctl_io.MemReady),
        .ctrl_o      (ctrl)
    );

    assign ctl_io.PCWrite     = ctrl.pc_write;
    assign ctl_io.PCWriteCond = ctrl.pc_write_cond;
    assign ctl_io.IorD        = ctrl.iord;
    assign ctl_io.MemRead     = ctrl.mem_read;
    assign ctl_io.MemWrite    = ctrl.mem_write;
    assign ctl_io.IRWrite     = ctrl.ir_write;
    assign ctl_io.RegDst      = ctrl.reg_dst;
    assign ctl_io.RegWrite    = ctrl.reg_write;
    assign ctl_io.MemToReg    = ctrl.mem_to_reg;
    assign ctl_io.SignExt     = ctrl.sign_ext;
    assign ctl_io.AluSrcA     = ctrl.alu_src_a;
    assign ctl_io.AluSrcB     = ctrl.alu_src_b;
    assign ctl_io.AluOp       = ctrl.alu_op;
    assign ctl_io.PCSource    = ctrl.pc_source;
    assign ctl_io.Illegal     = ctrl.illegal;

endmodule
